// File: rtl/ads131_pkg.sv
// Shared types and helpers for the ADS131A0x frame assembler.
// Optional CRC checking is built when ADS131_FRAME_CRC_EN is defined.
package ads131_pkg;

  typedef enum logic [1:0] {
    C_WAIT,
    C_CHAN,
    C_CRC
  } coll_state_t;

  typedef enum logic {
    O_IDLE,
    O_DRAIN
  } out_state_t;

  localparam logic [15:0] CRC_POLY = 16'h1021;
  localparam logic [15:0] CRC_INIT = 16'hFFFF;

  // Sign-extend the low `bits` bits of w to 64 bits.
  function automatic logic [63:0] sext(
    input logic [63:0] w,
    input int          bits
  );
    logic [63:0] r;
    for (int i = 0; i < 64; i++)
      r[i] = (i < bits) ? w[i] : w[6'(bits - 1)];
    return r;
  endfunction

endpackage

// File: rtl/ads131_crc16.sv
// Byte-serial CRC-16-CCITT engine: one byte of the loaded word per cycle,
// MSB-first; start reloads the seed together with the first word.
module ads131_crc16
  import ads131_pkg::*;
#(
  parameter int WORD_BITS = 24
) (
  input  logic                 system_clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 valid,
  input  logic [WORD_BITS-1:0] data,
  output logic                 busy,
  output logic [15:0]          crc
);

  localparam int NB = WORD_BITS / 8;

  logic [WORD_BITS-1:0] sh;
  logic [3:0]           cnt;

  function automatic logic [15:0] step(
    input logic [15:0] c,
    input logic [7:0]  b
  );
    logic [15:0] r;
    r = c ^ {b, 8'h00};
    for (int i = 0; i < 8; i++)
      r = r[15] ? ((r << 1) ^ CRC_POLY) : (r << 1);
    return r;
  endfunction

  always_ff @(posedge system_clock) begin
    if (reset) begin
      sh  <= '0;
      cnt <= '0;
      crc <= CRC_INIT;
    end else if (valid) begin
      sh  <= data;
      cnt <= 4'(NB);
      if (start)
        crc <= CRC_INIT;
    end else if (cnt != 4'd0) begin
      crc <= step(crc, sh[WORD_BITS-1 -: 8]);
      sh  <= sh << 8;
      cnt <= cnt - 4'd1;
    end
  end

  assign busy = (cnt != 4'd0);

endmodule

// File: rtl/ads131_frame_assembler.sv
// Groups ADS131A0x MISO words into frames and drains them as samples.
// Define ADS131_FRAME_CRC_EN to expect and verify a trailing CRC word.
module ads131_frame_assembler
  import ads131_pkg::*;
#(
  parameter int NUM_CH    = 4,
  parameter int WORD_BITS = 24,
  parameter int OUT_BITS  = 32,
  parameter int CNT_BITS  = 16
) (
  input  logic                 system_clock,
  input  logic                 reset,
  input  logic                 word_valid,
  input  logic [WORD_BITS-1:0] word_data,
  input  logic                 word_sof,
  output logic                 sample_valid,
  input  logic                 sample_ready,
  output logic [OUT_BITS-1:0]  sample_data,
  output logic [2:0]           sample_ch,
  output logic                 sample_last,
  output logic [15:0]          status_word,
  output logic [CNT_BITS-1:0]  frame_cnt,
  output logic [CNT_BITS-1:0]  ovf_cnt,
  output logic                 frame_err,
  output logic                 crc_err
);

  localparam logic [2:0] LAST = 3'(NUM_CH - 1);

  coll_state_t          cstate;
  out_state_t           ostate;
  logic [WORD_BITS-1:0] coll_buf [8];
  logic [WORD_BITS-1:0] out_buf  [8];
  logic [WORD_BITS-1:0] frame    [8];
  logic [15:0]          coll_status;
  logic [2:0]           widx;
  logic [2:0]           ridx;
  logic                 sof;
  logic                 chan_ok;
  logic                 complete;
  logic                 out_idle;
  logic                 accept;
  logic                 drop;

  assign sof = word_valid && word_sof;

`ifdef ADS131_FRAME_CRC_EN
  logic        crc_busy;
  logic        crc_hit;
  logic        crc_bad;
  logic [15:0] crc_val;

  ads131_crc16 #(
    .WORD_BITS(WORD_BITS)
  ) u_crc (
    .system_clock(system_clock),
    .reset       (reset),
    .start       (sof),
    .valid       (sof || (cstate == C_CHAN && chan_ok)),
    .data        (word_data),
    .busy        (crc_busy),
    .crc         (crc_val)
  );

  assign chan_ok  = word_valid && !word_sof && !crc_busy;
  assign crc_hit  = (word_data[WORD_BITS-1 -: 16] == crc_val);
  assign complete = (cstate == C_CRC) && chan_ok && crc_hit;
  assign crc_bad  = (cstate == C_CRC) && chan_ok && !crc_hit;
`else
  assign chan_ok  = word_valid && !word_sof;
  assign complete = (cstate == C_CHAN) && chan_ok && (widx == LAST);
  assign crc_err  = 1'b0;
`endif

  // A drain ending on the completing cycle frees the output buffer.
  assign out_idle = (ostate == O_IDLE) ||
                    (sample_ready && ridx == LAST);
  assign accept   = complete && out_idle;
  assign drop     = complete && !out_idle;

  always_comb begin
    for (int i = 0; i < 8; i++)
      frame[i] = coll_buf[i];
`ifndef ADS131_FRAME_CRC_EN
    frame[LAST] = word_data;
`endif
  end

  always_ff @(posedge system_clock) begin
    if (reset) begin
      cstate      <= C_WAIT;
      widx        <= '0;
      coll_status <= '0;
      status_word <= '0;
      frame_cnt   <= '0;
      ovf_cnt     <= '0;
      frame_err   <= 1'b0;
`ifdef ADS131_FRAME_CRC_EN
      crc_err     <= 1'b0;
`endif
    end else begin
      if (sof) begin
        if (cstate != C_WAIT)
          frame_err <= 1'b1;
        coll_status <= word_data[WORD_BITS-1 -: 16];
        widx        <= '0;
        cstate      <= C_CHAN;
      end else if (word_valid) begin
        unique case (cstate)
          C_CHAN: begin
            if (chan_ok) begin
              coll_buf[widx] <= word_data;
              widx           <= widx + 3'd1;
              if (widx == LAST)
`ifdef ADS131_FRAME_CRC_EN
                cstate <= C_CRC;
            end else begin
              frame_err <= 1'b1;
`else
                cstate <= C_WAIT;
`endif
            end
          end
`ifdef ADS131_FRAME_CRC_EN
          C_CRC: begin
            if (chan_ok) begin
              cstate <= C_WAIT;
              if (crc_bad)
                crc_err <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
          end
`endif
          default: ;
        endcase
      end
      if (accept) begin
        status_word <= coll_status;
        frame_cnt   <= frame_cnt + 1'b1;
      end
      if (drop && ovf_cnt != '1)
        ovf_cnt <= ovf_cnt + 1'b1;
    end
  end

  always_ff @(posedge system_clock) begin
    if (reset) begin
      ostate <= O_IDLE;
      ridx   <= '0;
    end else if (accept) begin
      for (int i = 0; i < 8; i++)
        out_buf[i] <= frame[i];
      ridx   <= '0;
      ostate <= O_DRAIN;
    end else if (ostate == O_DRAIN && sample_ready) begin
      if (ridx == LAST) begin
        ridx   <= '0;
        ostate <= O_IDLE;
      end else begin
        ridx <= ridx + 3'd1;
      end
    end
  end

  assign sample_valid = (ostate == O_DRAIN);
  assign sample_ch    = ridx;
  assign sample_last  = sample_valid && (ridx == LAST);
  assign sample_data  = sample_valid
                      ? OUT_BITS'(sext(64'(out_buf[ridx]), WORD_BITS))
                      : '0;

endmodule

// File: doc/ads131_frame_assembler.md
Name: ads131_frame_assembler

Overview:
- Downstream consumer of the ADS131A0x SPI master's received-word stream.
- Groups MISO words into ADC data frames: status word, NUM_CH channel words, and an optional CRC word.
- Sign-extends each channel sample and emits it as a valid/ready sample stream with a channel index.
- Reports frame, overflow and CRC error status for the main design.

Parameters:
NUM_CH, 4, channel words per frame (1..8)
WORD_BITS, 24, SPI word width in bits; channel samples use all WORD_BITS
OUT_BITS, 32, output sample width; sign-extended from WORD_BITS; must be >= WORD_BITS
CNT_BITS, 16, width of frame and overflow counters

Ports:
system_clock  in  1  sole clock
reset  in  1  synchronous, active-high reset
word_valid  in  1  one-cycle strobe: word_data holds a completed SPI word
word_data  in  WORD_BITS  received MISO word, MSB first as shifted
word_sof  in  1  qualifies word_valid: first word after SPI_CS falling edge
sample_valid  out  1  sample_data/sample_ch valid
sample_ready  in  1  downstream accepts sample when high with sample_valid
sample_data  out  OUT_BITS  sign-extended channel sample
sample_ch  out  3  channel index 0..NUM_CH-1
sample_last  out  1  high on the channel NUM_CH-1 beat
status_word  out  16  word_data[WORD_BITS-1 -: 16] of the last accepted frame
frame_cnt  out  CNT_BITS  accepted frames, wraps
ovf_cnt  out  CNT_BITS  dropped frames (output busy), saturates at all-ones
frame_err  out  1  sticky: short frame (SOF before completion); cleared only by reset
crc_err  out  1  sticky CRC mismatch (feature only; otherwise tied 0)

Behaviour:
- Reset (synchronous): all outputs 0, both FSMs idle, buffers invalid.
- Collect FSM states:
  - C_WAIT: ignores words unless word_sof is set. word_valid&word_sof -> latch status, widx=0, go to C_CHAN.
  - C_CHAN: each word_valid stores word_data into coll_buf[widx], widx++. On widx==NUM_CH-1 -> C_CRC if the feature is enabled, else frame complete and go to C_WAIT.
  - C_CRC: described under Optional Feature.
- Any word_valid&word_sof while in C_CHAN/C_CRC:
  - set frame_err;
  - discard the partial frame;
  - treat the word as the status of a new frame (stay in or re-enter C_CHAN, widx=0).
- word_valid without word_sof in C_WAIT (trailing/extra words) is ignored.
- Frame complete:
  - If the output side is idle in the same cycle, copy coll_buf->out_buf, update status_word, frame_cnt++, start draining on the next cycle.
  - Else drop the frame, ovf_cnt++ (saturating); status_word is unchanged.
- Output FSM states:
  - O_IDLE: sample_valid=0.
  - O_DRAIN: sample_valid=1, sample_ch=ridx, sample_data=sext(out_buf[ridx]).
  - On sample_valid&sample_ready, ridx++. On the last beat (sample_last=1) return to O_IDLE.
  - Outputs are held stable while stalled.
- Latency: first sample_valid one cycle after the last channel word (or CRC word) strobe. Back-to-back frames are accepted if the drain finishes no later than the completing cycle; a drain that finishes in the same cycle as a frame completes counts as idle.
- Sign extension: sample_data = {{(OUT_BITS-WORD_BITS){w[WORD_BITS-1]}}, w}. Example: 0x800000 -> 0xFF800000.
- Counters: frame_cnt wraps 0xFFFF->0; ovf_cnt holds at 0xFFFF.
- Reset mid-frame or mid-drain: immediate return to the reset state; no partial output.

Optional Feature:
- Macro ADS131_FRAME_CRC_EN.
- Defined:
  - Frame carries one extra word; CRC is in its upper 16 bits.
  - CRC-16-CCITT, polynomial 0x1021, init 0xFFFF, computed bytewise MSB-first over the status word and all channel words. All WORD_BITS bits are fed, one byte per cycle, by the sub-module.
  - Mismatch: set crc_err and discard the frame (no frame_cnt or ovf_cnt change).
  - Match: normal completion.
  - word_valid arriving while the CRC unit is still busy (WORD_BITS/8 cycles per word): the word is dropped and frame_err is set.
- Undefined: no CRC word is expected, crc_err is tied 0, no CRC logic is synthesized.

Decomposition:
- Package ads131_pkg holds:
  - collect/output state enums;
  - CRC_POLY=16'h1021 and CRC_INIT=16'hFFFF;
  - function sext().
- Sub-module ads131_crc16 (byte-serial CRC engine with start/valid/busy), instantiated only under the macro.

Test Plan:
1. Frame SOF 0x2240_00, then 0x000001, 0x7FFFFF, 0x800000, 0xFFFFFF, with sample_ready=1 -> samples 0x00000001, 0x007FFFFF, 0xFF800000, 0xFFFFFFFF; ch 0..3; sample_last on ch3; status_word=0x2240; frame_cnt=1.
2. Same frame with sample_ready=0 for 10 cycles, then 1 -> sample_valid held on ch0 with stable data; all 4 samples delivered in order.
3. Second full frame completes while the first is stalled -> ovf_cnt=1, frame_cnt=1, first frame's samples unaltered.
4. SOF, 2 channel words, then a new SOF plus a full frame -> frame_err=1; only the second frame is output; frame_cnt=1.
5. Words without SOF after reset -> no output, counters 0; assert reset during drain -> sample_valid=0 next cycle.
6. ADS131_FRAME_CRC_EN: correct CRC word -> frame output; CRC with one bit flipped -> crc_err=1, no samples, frame_cnt unchanged.
